// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies OAM_LEN bytes from a CPU-selected 256-byte page into
// OAM over the shared peripheral bus, one read/latch/write triple per byte.
module oam_dma_controller #(
  parameter int                   ADDR_SIZE = 16,
  parameter int                   DATA_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] DMA_REG   = 16'hFF46,
  parameter logic [ADDR_SIZE-1:0] OAM_LOC   = 16'hFE00,
  parameter int                   OAM_LEN   = 160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [DATA_SIZE-1:0] cpu_rdata,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [DATA_SIZE-1:0] bus_wdata,
  input  logic [DATA_SIZE-1:0] bus_rdata,
  output logic                 bus_rd,
  output logic                 bus_wr,
  output logic                 dma_active,
  output logic                 dma_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  logic [2:0]           state;
  logic [7:0]           src_page;
  logic [7:0]           idx;
  logic [DATA_SIZE-1:0] dbuf;
  logic                 start_wr;
  logic                 last_byte;

  assign start_wr   = cpu_we && (cpu_addr == DMA_REG);
  assign last_byte  = (idx == LAST_IDX);
  assign dma_active = (state != S_IDLE);
  assign bus_req    = dma_active;
  assign cpu_rdata  = (cpu_re && (cpu_addr == DMA_REG)) ? DATA_SIZE'(src_page) : '0;

  // Strobes only fire in a granted RD/WR cycle; address and data stay at zero otherwise.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      S_RD: begin
        if (bus_gnt) begin
          bus_rd   = 1'b1;
          bus_addr = ADDR_SIZE'({src_page, idx});
        end
      end
      S_WR: begin
        if (bus_gnt) begin
          bus_wr    = 1'b1;
          bus_addr  = OAM_LOC + ADDR_SIZE'(idx);
          bus_wdata = dbuf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      src_page <= '0;
      idx      <= '0;
      dbuf     <= '0;
      dma_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      dma_done <= 1'b0;
      // A register write restarts from any state, abandoning the byte in flight.
      if (start_wr) begin
        src_page <= 8'(cpu_wdata);
        idx      <= '0;
        state    <= S_REQ;
      end else begin
        case (state)
          S_IDLE: ;
          S_REQ: begin
            if (bus_gnt) state <= S_RD;
          end
          S_RD: begin
            if (bus_gnt) state <= S_LATCH;
          end
          S_LATCH: begin
            dbuf  <= bus_rdata;
            state <= S_WR;
          end
          S_WR: begin
            if (bus_gnt) begin
              if (last_byte) begin
                state    <= S_IDLE;
                dma_done <= 1'b1;
              end else begin
                idx   <= idx + 8'd1;
                state <= S_RD;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (reset) !(bus_rd && bus_wr));
  a_idx_in_range:     assert property (@(posedge clk) disable iff (reset) idx <= LAST_IDX);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: a source-memory model feeds reads and a
// queue of expected OAM writes is compared against every bus write the DUT issues.
module tb_oam_dma_controller;

  localparam logic [15:0] DMA_REG = 16'hFF46;
  localparam logic [15:0] OAM_LOC = 16'hFE00;
  localparam int          OAM_LEN = 160;
  localparam int          TIMEOUT = 3000;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef enum int { P_REQ, P_RD, P_LATCH, P_WR, P_DONE } phase_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        dma_active;
  logic        dma_done;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:OAM_LEN-1];
  wr_t        exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  oam_dma_controller #(
    .ADDR_SIZE(16), .DATA_SIZE(8), .DMA_REG(DMA_REG), .OAM_LOC(OAM_LOC), .OAM_LEN(OAM_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < OAM_LEN; i++)
      exp_q.push_back(wr_t'{addr: OAM_LOC + 16'(i), data: mem[{page, 8'(i)}]});
  endtask

  task automatic read_reg(input logic [15:0] addr, input logic re, output logic [7:0] d);
    @(posedge clk); #2;
    cpu_addr = addr;
    cpu_re   = re;
    #1 d = cpu_rdata;
    cpu_re = 1'b0;
  endtask

  // Runs one transfer from 'page'; optionally restarts or resets after a given write count.
  task automatic run_dma(input logic [7:0] page, input bit rnd_gnt, input int restart_at,
                         input logic [7:0] restart_page, input int reset_at,
                         output int done_cyc, output int n_done, output int lows);
    phase_t      ph        = P_REQ;
    bit          track     = 1'b1;
    bit          restarted = 1'b0;
    bit          prev_rd   = 1'b0;
    logic [15:0] prev_addr = '0;
    int          cyc       = 0;
    int          end_cyc   = 0;
    int          wr_cnt    = 0;
    int          reset_cyc = 0;
    logic        exp_rd, exp_wr;
    wr_t         e;
    done_cyc = 0;
    n_done   = 0;
    lows     = 0;
    exp_q.delete();
    push_page(page);
    @(posedge clk); #1;
    cpu_addr  = DMA_REG;
    cpu_wdata = page;
    cpu_we    = 1'b1;
    bus_gnt   = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cyc    = 1;
    while (1) begin
      @(negedge clk);
      bus_rdata = prev_rd ? mem[prev_addr] : 8'($urandom);
      prev_rd   = bus_rd;
      prev_addr = bus_addr;
      if (bus_wr) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h, expected no write", cyc, bus_addr, bus_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus_addr, bus_wdata} !== e) begin
            n_fail++;
            $display("FAIL oam_write cyc=%0d got addr=%h data=%h, expected addr=%h data=%h",
                     cyc, bus_addr, bus_wdata, e.addr, e.data);
          end
        end
        if (bus_addr >= OAM_LOC && bus_addr < OAM_LOC + 16'(OAM_LEN))
          oam[8'(bus_addr - OAM_LOC)] = bus_wdata;
        wr_cnt++;
      end else if (!bus_rd) begin
        n_tests++;
        if (bus_addr !== 16'h0 || bus_wdata !== 8'h0) begin
          n_fail++;
          $display("FAIL idle_bus cyc=%0d got addr=%h wdata=%h, expected 0", cyc, bus_addr, bus_wdata);
        end
      end
      if (dma_done) begin
        n_done++;
        n_tests++;
        if (dma_active !== 1'b0) begin
          n_fail++;
          $display("FAIL active_at_done cyc=%0d got dma_active=%b, expected 0", cyc, dma_active);
        end
        if (done_cyc == 0) begin
          done_cyc = cyc;
          end_cyc  = cyc + 4;
        end
      end
      if (track) begin
        exp_rd = (ph == P_RD) && bus_gnt;
        exp_wr = (ph == P_WR) && bus_gnt;
        n_tests++;
        if ({bus_rd, bus_wr, bus_req} !== {exp_rd, exp_wr, ph != P_DONE}) begin
          n_fail++;
          $display("FAIL strobe_timing cyc=%0d got rd/wr/req=%b%b%b, expected %b%b%b",
                   cyc, bus_rd, bus_wr, bus_req, exp_rd, exp_wr, ph != P_DONE);
        end
        case (ph)
          P_REQ:   if (bus_gnt) ph = P_RD;
          P_RD:    if (bus_gnt) ph = P_LATCH; else lows++;
          P_LATCH: ph = P_WR;
          P_WR:    if (!bus_gnt) lows++; else ph = (wr_cnt == OAM_LEN) ? P_DONE : P_RD;
          default: ;
        endcase
      end
      if (reset_cyc != 0 && cyc == reset_cyc + 1) begin
        n_tests++;
        if ({bus_req, bus_rd, bus_wr, dma_active, dma_done} !== 5'b0 || bus_addr !== 16'h0 || bus_wdata !== 8'h0) begin
          n_fail++;
          $display("FAIL reset_abort got req/rd/wr/act/done=%b%b%b%b%b addr=%h wdata=%h, expected all 0",
                   bus_req, bus_rd, bus_wr, dma_active, dma_done, bus_addr, bus_wdata);
        end
      end
      if (end_cyc != 0 && cyc >= end_cyc) break;
      if (cyc >= TIMEOUT) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout got no completion after %0d cycles, expected dma_done", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      reset   = 1'b0;
      cpu_we  = 1'b0;
      bus_gnt = (rnd_gnt && ph != P_REQ) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (restart_at > 0 && !restarted && wr_cnt == restart_at) begin
        restarted = 1'b1;
        track     = 1'b0;
        cpu_addr  = DMA_REG;
        cpu_wdata = restart_page;
        cpu_we    = 1'b1;
        exp_q.delete();
        push_page(restart_page);
      end
      if (reset_at > 0 && reset_cyc == 0 && wr_cnt == reset_at) begin
        reset     = 1'b1;
        reset_cyc = cyc;
        end_cyc   = cyc + 20;
        track     = 1'b0;
        exp_q.delete();
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    bus_gnt   = 1'b1;
    bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus_req, bus_rd, bus_wr, dma_active, dma_done} !== 5'b0 || bus_addr !== 16'h0 || bus_wdata !== 8'h0) begin
        n_fail++;
        $display("FAIL reset_idle cycle=%0d got req/rd/wr/act/done=%b%b%b%b%b addr=%h, expected all 0",
                 i, bus_req, bus_rd, bus_wr, dma_active, dma_done, bus_addr);
      end
    end
    read_reg(DMA_REG, 1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_readback got %h, expected 00", d);
    end
  endtask

  task automatic test_other_addr();
    logic [7:0] d;
    @(posedge clk); #1;
    cpu_addr  = 16'hFF47;
    cpu_wdata = 8'hC0;
    cpu_we    = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus_req, dma_active, bus_rd, bus_wr} !== 4'b0) begin
        n_fail++;
        $display("FAIL other_addr cycle=%0d got req/act/rd/wr=%b%b%b%b, expected 0000",
                 i, bus_req, dma_active, bus_rd, bus_wr);
      end
    end
    read_reg(16'hFF47, 1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL other_addr_read got %h, expected 00", d);
    end
    read_reg(DMA_REG, 1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL other_addr_page got %h, expected 00", d);
    end
  endtask

  task automatic test_basic();
    int dc, nd, lw;
    logic [7:0] d;
    run_dma(8'hC0, 1'b0, 0, 8'h00, 0, dc, nd, lw);
    n_tests++;
    if (dc !== 482) begin
      n_fail++;
      $display("FAIL basic_done_cycle got %0d, expected 482", dc);
    end
    n_tests++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL basic_done_count got %0d, expected 1", nd);
    end
    for (int i = 0; i < OAM_LEN; i++) begin
      n_tests++;
      if (oam[i] !== mem[{8'hC0, 8'(i)}]) begin
        n_fail++;
        $display("FAIL basic_oam[%0d] got %h, expected %h", i, oam[i], mem[{8'hC0, 8'(i)}]);
      end
    end
    read_reg(DMA_REG, 1'b1, d);
    n_tests++;
    if (d !== 8'hC0) begin
      n_fail++;
      $display("FAIL basic_readback got %h, expected c0", d);
    end
  endtask

  task automatic test_random_gnt();
    int dc, nd, lw;
    run_dma(8'hC0, 1'b1, 0, 8'h00, 0, dc, nd, lw);
    n_tests++;
    if (dc !== 482 + lw) begin
      n_fail++;
      $display("FAIL gnt_done_cycle got %0d, expected %0d", dc, 482 + lw);
    end
    n_tests++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL gnt_done_count got %0d, expected 1", nd);
    end
    for (int i = 0; i < OAM_LEN; i++) begin
      n_tests++;
      if (oam[i] !== mem[{8'hC0, 8'(i)}]) begin
        n_fail++;
        $display("FAIL gnt_oam[%0d] got %h, expected %h", i, oam[i], mem[{8'hC0, 8'(i)}]);
      end
    end
  endtask

  task automatic test_restart();
    int dc, nd, lw;
    logic [7:0] d;
    run_dma(8'hC0, 1'b0, 50, 8'hC1, 0, dc, nd, lw);
    n_tests++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL restart_done_count got %0d, expected 1", nd);
    end
    for (int i = 0; i < OAM_LEN; i++) begin
      n_tests++;
      if (oam[i] !== mem[{8'hC1, 8'(i)}]) begin
        n_fail++;
        $display("FAIL restart_oam[%0d] got %h, expected %h", i, oam[i], mem[{8'hC1, 8'(i)}]);
      end
    end
    read_reg(DMA_REG, 1'b1, d);
    n_tests++;
    if (d !== 8'hC1) begin
      n_fail++;
      $display("FAIL restart_readback got %h, expected c1", d);
    end
    read_reg(DMA_REG, 1'b0, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL read_without_re got %h, expected 00", d);
    end
  endtask

  task automatic test_reset_mid();
    int dc, nd, lw;
    logic [7:0] d;
    logic [7:0] snap [0:OAM_LEN-1];
    for (int i = 0; i < OAM_LEN; i++) snap[i] = oam[i];
    run_dma(8'hC2, 1'b0, 0, 8'h00, 80, dc, nd, lw);
    n_tests++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_done got %0d pulses, expected 0", nd);
    end
    for (int i = 0; i < OAM_LEN; i++) begin
      n_tests++;
      if (i < 80 && oam[i] !== mem[{8'hC2, 8'(i)}]) begin
        n_fail++;
        $display("FAIL reset_mid_oam[%0d] got %h, expected %h", i, oam[i], mem[{8'hC2, 8'(i)}]);
      end else if (i >= 80 && oam[i] !== snap[i]) begin
        n_fail++;
        $display("FAIL reset_mid_kept[%0d] got %h, expected %h", i, oam[i], snap[i]);
      end
    end
    read_reg(DMA_REG, 1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_readback got %h, expected 00", d);
    end
  endtask

  initial begin
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 256; i++)
        mem[{8'hC0 + 8'(p), 8'(i)}] = 8'($urandom);
    test_reset();
    test_other_addr();
    test_basic();
    test_random_gnt();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequencer that copies a 160-byte sprite table from any 256-byte-aligned source page into OAM, driving the shared peripheral bus on behalf of the CPU. It sits between the CPU register decode and the bus arbiter feeding the graphics peripheral. A CPU write to the DMA register starts a transfer; while it runs, the block holds the bus and flags the CPU as blocked from non-HRAM accesses.

## Interface
Parameters:
- ADDR_SIZE, 16, bus address width
- DATA_SIZE, 8, bus data width
- DMA_REG, 16'hFF46, CPU-visible start/source register address
- OAM_LOC, 16'hFE00, OAM base address
- OAM_LEN, 160, bytes per transfer

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_SIZE  CPU register-access address
- cpu_wdata  in  DATA_SIZE  CPU write data
- cpu_we  in  1  CPU write strobe, sampled on rising clk
- cpu_re  in  1  CPU read strobe
- cpu_rdata  out  DATA_SIZE  combinational: src_page when cpu_re && cpu_addr==DMA_REG, else 0
- bus_req  out  1  bus request to arbiter
- bus_gnt  in  1  bus grant from arbiter
- bus_addr  out  ADDR_SIZE  master address
- bus_wdata  out  DATA_SIZE  master write data
- bus_rdata  in  DATA_SIZE  read data, valid the cycle after bus_rd
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- dma_active  out  1  transfer in progress (CPU stall flag)
- dma_done  out  1  one-cycle pulse on completion

## Operation
- Registers: src_page[7:0], idx[7:0], dbuf[DATA_SIZE-1:0], state.
- States: IDLE, REQ, RD, LATCH, WR.
- IDLE: all bus outputs 0. On cpu_we && cpu_addr==DMA_REG: src_page<=cpu_wdata, idx<=0, ->REQ.
- REQ: bus_req=1. bus_gnt=1 -> RD; else stay.
- RD: bus_req=1. If bus_gnt: bus_rd=1, bus_addr={src_page,idx}, ->LATCH. If !bus_gnt: no strobe, stay.
- LATCH: bus_req=1, no strobe; dbuf<=bus_rdata; ->WR.
- WR: bus_req=1. If bus_gnt: bus_wr=1, bus_addr=OAM_LOC+idx, bus_wdata=dbuf; if idx==OAM_LEN-1 ->IDLE and dma_done<=1, else idx<=idx+1, ->RD. If !bus_gnt: stay, no strobe.
- dma_active=1 in every state except IDLE.
- bus_addr/bus_wdata are 0 whenever no strobe is asserted.
- Restart: DMA_REG write in any non-IDLE state loads new src_page, idx<=0, ->REQ; in-flight byte is abandoned (no bus_wr that cycle's successor). Restart has priority over all other transitions.
- src_page taken as-is; no source-range remapping.
- idx never exceeds OAM_LEN-1; no wrap beyond OAM.

## Timing
- Reset: state=IDLE, src_page=0, idx=0, dbuf=0, dma_done=0; bus_req, bus_rd, bus_wr, dma_active=0, bus_addr=0, bus_wdata=0. Reset mid-transfer aborts immediately; no further strobes.
- Start write sampled at edge E0: REQ in cycle 1 (dma_active, bus_req high).
- Grant held high: RD cycle 2; each byte RD/LATCH/WR = 3 cycles; last WR in cycle 481; IDLE and dma_done=1 in cycle 482 only; dma_active low from 482.
- Each grant-low cycle in RD or WR adds exactly one cycle; LATCH ignores bus_gnt.
- cpu_rdata combinational, zero-latency; reflects new src_page the cycle after the write.

## Test plan
- Reset, then idle: bus_req/rd/wr/dma_active/dma_done all 0 for 10 cycles; cpu read of DMA_REG -> 0.
- Preload page 0xC0 with random bytes, write 0xC0 to DMA_REG, gnt tied 1 -> 160 bus_wr to FE00..FE9F matching source, dma_done in cycle 482, readback of DMA_REG = 0xC0.
- Same transfer with bus_gnt toggled pseudo-randomly -> identical OAM contents; total cycles = 482 + grant-low cycles in RD/WR.
- Restart: write 0xC1 at byte 50 of a 0xC0 transfer -> OAM ends with page 0xC1 contents, single dma_done.
- Reset asserted at byte 80 -> all outputs 0 next cycle, no dma_done, OAM bytes 80+ unchanged.
- Write to non-DMA address (0xFF47) -> no transfer, bus_req stays 0.
